// File: rtl/bip2_pkg.sv
// BIP-2 shared constants: opcode values, control-FSM state codes, ALU
// operation codes and datapath mux select values.
package bip2_pkg;

    // Opcodes are held at 32 bits so the decoder can compare against them
    // whatever the configured opcode field width.
    localparam logic [31:0] OP_HLT       = 32'd0;
    localparam logic [31:0] OP_STO       = 32'd1;
    localparam logic [31:0] OP_LD        = 32'd2;
    localparam logic [31:0] OP_LDI       = 32'd3;
    localparam logic [31:0] OP_ADD       = 32'd4;
    localparam logic [31:0] OP_ADDI      = 32'd5;
    localparam logic [31:0] OP_SUB       = 32'd6;
    localparam logic [31:0] OP_SUBI      = 32'd7;
    localparam logic [31:0] OP_BEQ       = 32'd8;
    localparam logic [31:0] OP_BNE       = 32'd9;
    localparam logic [31:0] OP_BGT       = 32'd10;
    localparam logic [31:0] OP_BGE       = 32'd11;
    localparam logic [31:0] OP_BLT       = 32'd12;
    localparam logic [31:0] OP_BLE       = 32'd13;
    localparam logic [31:0] OP_JMP       = 32'd14;
    localparam logic [31:0] OP_NOP_FIRST = 32'd15;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    localparam logic SELA_BMUX = 1'b0;
    localparam logic SELA_ALU  = 1'b1;
    localparam logic SELB_RAM  = 1'b0;
    localparam logic SELB_IMM  = 1'b1;

endpackage

// File: rtl/bip2_decode.sv
// BIP-2 instruction decoder (purely combinational).
// Ports:
//   opcode        opcode field of the instruction register
//   z, n          accumulator zero / negative flags
//   sel_a, sel_b  accumulator source and B-mux selects
//   wr_acc        accumulator write enable
//   op            ALU operation (add / subtract)
//   wr_ram        data RAM write enable
//   branch_taken  branch/jump condition satisfied for this opcode
//   is_halt       opcode is HLT
module bip2_decode
    import bip2_pkg::*;
#(
    parameter int OPC_W = 5
) (
    input  logic [OPC_W-1:0] opcode,
    input  logic             z,
    input  logic             n,
    output logic             sel_a,
    output logic             sel_b,
    output logic             wr_acc,
    output logic             op,
    output logic             wr_ram,
    output logic             branch_taken,
    output logic             is_halt
);

    logic [31:0] opc;

    always_comb begin
        opc          = 32'(opcode);
        sel_a        = SELA_BMUX;
        sel_b        = SELB_RAM;
        wr_acc       = 1'b0;
        op           = ALU_ADD;
        wr_ram       = 1'b0;
        branch_taken = 1'b0;
        is_halt      = 1'b0;
        case (opc)
            OP_HLT:  is_halt = 1'b1;
            OP_STO:  wr_ram  = 1'b1;
            OP_LD:   wr_acc  = 1'b1;
            OP_LDI: begin
                wr_acc = 1'b1;
                sel_b  = SELB_IMM;
            end
            OP_ADD: begin
                wr_acc = 1'b1;
                sel_a  = SELA_ALU;
            end
            OP_ADDI: begin
                wr_acc = 1'b1;
                sel_a  = SELA_ALU;
                sel_b  = SELB_IMM;
            end
            OP_SUB: begin
                wr_acc = 1'b1;
                sel_a  = SELA_ALU;
                op     = ALU_SUB;
            end
            OP_SUBI: begin
                wr_acc = 1'b1;
                sel_a  = SELA_ALU;
                sel_b  = SELB_IMM;
                op     = ALU_SUB;
            end
            OP_BEQ:  branch_taken = z;
            OP_BNE:  branch_taken = !z;
            OP_BGT:  branch_taken = !z && !n;
            OP_BGE:  branch_taken = !n;
            OP_BLT:  branch_taken = n;
            OP_BLE:  branch_taken = z || n;
            OP_JMP:  branch_taken = 1'b1;
            // OP_NOP_FIRST and above: no controls
            default: ;
        endcase
    end

endmodule

// File: rtl/bip2_control_mc.sv
// BIP-2 multicycle control unit: owns PC and IR, fetches from instruction
// memory with a valid handshake, executes one instruction per EXEC cycle and
// supports halt/resume.
// Ports:
//   Clock_i, Reset_i     clock, synchronous active-high reset
//   Instr_i, Instr_valid_i  instruction word and its valid strobe
//   z_i, n_i             accumulator zero / negative flags
//   Run_i                resume pulse while halted
//   ADDR_im_o            instruction address (PC)
//   DATA_im_o            operand field of the IR
//   SellA_o, SellB_o, WrAcc_o, Op_o, WrRam_o  datapath controls
//   Halted_o             core is halted
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_FETCH | present PC, wait for Instr_valid_i, latch IR
// ST_EXEC  | drive decoded controls for one cycle, update PC
// ST_HALT  | HLT executed, PC frozen until Run_i
module bip2_control_mc
    import bip2_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int OPC_W    = 5,
    parameter int ADDR_W   = 11,
    parameter int RESET_PC = 0
) (
    input  logic              Clock_i,
    input  logic              Reset_i,
    input  logic [DATA_W-1:0] Instr_i,
    input  logic              Instr_valid_i,
    input  logic              z_i,
    input  logic              n_i,
    input  logic              Run_i,
    output logic [ADDR_W-1:0] ADDR_im_o,
    output logic [ADDR_W-1:0] DATA_im_o,
    output logic              SellA_o,
    output logic              SellB_o,
    output logic              WrAcc_o,
    output logic              Op_o,
    output logic              WrRam_o,
    output logic              Halted_o
);

    generate
        if (ADDR_W > DATA_W - OPC_W) begin : g_bad_width
            $error("bip2_control_mc: ADDR_W must not exceed DATA_W-OPC_W");
        end
    endgenerate

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;

    logic dec_sel_a, dec_sel_b, dec_wr_acc, dec_op, dec_wr_ram;
    logic branch_taken, is_halt;
    logic exec_en;

    bip2_decode #(
        .OPC_W (OPC_W)
    ) u_decode (
        .opcode       (ir[DATA_W-1 -: OPC_W]),
        .z            (z_i),
        .n            (n_i),
        .sel_a        (dec_sel_a),
        .sel_b        (dec_sel_b),
        .wr_acc       (dec_wr_acc),
        .op           (dec_op),
        .wr_ram       (dec_wr_ram),
        .branch_taken (branch_taken),
        .is_halt      (is_halt)
    );

    // Reset gates the controls combinationally so an EXEC cycle that is
    // being reset never commits a write.
    always_comb begin
        exec_en   = (state == ST_EXEC) && !Reset_i;
        ADDR_im_o = pc;
        DATA_im_o = ir[ADDR_W-1:0];
        SellA_o   = exec_en && dec_sel_a;
        SellB_o   = exec_en && dec_sel_b;
        WrAcc_o   = exec_en && dec_wr_acc;
        Op_o      = exec_en && dec_op;
        WrRam_o   = exec_en && dec_wr_ram;
        Halted_o  = (state == ST_HALT) && !Reset_i;
    end

    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            state <= ST_FETCH;
            pc    <= ADDR_W'(RESET_PC);
            ir    <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (Instr_valid_i) begin
                        ir    <= Instr_i;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (is_halt) begin
                        state <= ST_HALT;
                    end else begin
                        pc    <= branch_taken ? ir[ADDR_W-1:0] : pc + ADDR_W'(1);
                        state <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    if (Run_i) begin
                        pc    <= pc + ADDR_W'(1);
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: doc/bip2_control_mc.md
Name: bip2_control_mc

Overview:
- Parametrised multicycle control unit for the BIP-2 processor.
- Owns the program counter and the instruction register, and handshakes with instruction memory.
- Decodes the full BIP-2 instruction set: HLT, STO, LD, LDI, ADD, ADDI, SUB, SUBI, the six conditional branches and JMP.
- Drives the accumulator/RAM datapath with the same SellA/SellB/WrAcc/Op/WrRam control set, and adds halt/resume.

Parameters:
- DATA_W, 16, instruction word width.
- OPC_W, 5, opcode field width, taken from bits [DATA_W-1 -: OPC_W].
- ADDR_W, 11, operand and PC width, taken from bits [ADDR_W-1:0]. ADDR_W <= DATA_W-OPC_W is required; elaboration fails otherwise.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- Clock_i  in  1  single clock; all state updates on the rising edge.
- Reset_i  in  1  synchronous, active-high reset.
- Instr_i  in  DATA_W  instruction word from instruction memory.
- Instr_valid_i  in  1  Instr_i holds the word at ADDR_im_o.
- z_i  in  1  accumulator == 0 flag.
- n_i  in  1  accumulator negative flag.
- Run_i  in  1  resume pulse while halted.
- ADDR_im_o  out  ADDR_W  instruction address (the PC).
- DATA_im_o  out  ADDR_W  operand field of the IR (immediate or RAM address).
- SellA_o  out  1  accumulator source: 1 = ALU result, 0 = B-mux output.
- SellB_o  out  1  B-mux select: 1 = immediate (DATA_im_o), 0 = RAM data.
- WrAcc_o  out  1  accumulator write enable.
- Op_o  out  1  ALU operation: 0 = add, 1 = subtract.
- WrRam_o  out  1  data RAM write enable.
- Halted_o  out  1  core is in HALT.

Behaviour:
- State machine: FETCH, EXEC, HALT.
- Reset (sampled at the edge):
  - state <= FETCH, PC <= RESET_PC, IR <= 0 (the HLT encoding).
  - While Reset_i is high, WrAcc_o, WrRam_o, SellA_o, SellB_o, Op_o and Halted_o are forced to 0 combinationally. A reset asserted during EXEC therefore never produces a write.
- FETCH:
  - ADDR_im_o = PC; all controls 0.
  - Instr_valid_i=1 at the edge: IR <= Instr_i, go to EXEC.
  - Instr_valid_i=0: hold, with no PC or IR change.
- EXEC, one cycle:
  - Controls are decoded from the IR and valid for the whole cycle. DATA_im_o = IR[ADDR_W-1:0] in every state.
  - Decode table:
    - LD: WrAcc=1, SellA=0, SellB=0.
    - LDI: WrAcc=1, SellA=0, SellB=1.
    - ADD: WrAcc=1, SellA=1, SellB=0, Op=0.
    - ADDI: WrAcc=1, SellA=1, SellB=1, Op=0.
    - SUB: same as ADD with Op=1.
    - SUBI: same as ADDI with Op=1.
    - STO: WrRam=1.
    - All other opcodes: all controls 0.
  - Opcodes: HLT=0, STO=1, LD=2, LDI=3, ADD=4, ADDI=5, SUB=6, SUBI=7, BEQ=8, BNE=9, BGT=10, BGE=11, BLT=12, BLE=13, JMP=14. Opcodes 15 and above are NOPs.
  - Branch conditions: BEQ z; BNE !z; BGT !z&!n; BGE !n; BLT n; BLE z|n; JMP always.
  - Flags are sampled in the EXEC cycle. They reflect the accumulator before this instruction's write.
  - At the edge, branch taken: PC <= operand, go to FETCH.
  - HLT: PC unchanged, go to HALT.
  - Otherwise: PC <= PC+1 modulo 2^ADDR_W (0x7FF wraps to 0), go to FETCH.
- HALT:
  - Halted_o=1, all controls 0, PC holds.
  - Run_i=1 at the edge: PC <= PC+1, go to FETCH.
  - Run_i is ignored outside HALT.
- Reset has priority over every other event, including Run_i and Instr_valid_i.
- Latency: at least 2 cycles per instruction (FETCH + EXEC). Each wait cycle with Instr_valid_i=0 adds 1.

Decomposition:
- Package bip2_pkg holds:
  - the opcode localparams, including the NOP range start of 15;
  - the state encoding, FETCH/EXEC/HALT;
  - the ALU op constants ALU_ADD=0 and ALU_SUB=1;
  - the SellA/SellB select constants.
- One combinational sub-module, bip2_decode: opcode, z and n in; the five control bits, branch_taken and is_halt out.
- The parent holds the FSM, PC and IR.

Test Plan:
- Reset: hold Reset_i 2 cycles with Instr_valid_i=1 -> ADDR_im_o=0, all controls and Halted_o 0. One cycle after release, ADDR_im_o is still 0 and the FSM is in FETCH.
- LDI 2 (0x1802) valid at PC 0 -> next cycle WrAcc=1, SellA=0, SellB=1, DATA_im_o=2. The cycle after, ADDR_im_o=1.
- SUBI 1 (0x3801) -> EXEC shows WrAcc=1, SellA=1, SellB=1, Op=1. Then with z_i=1, BEQ 0x7FF (0x47FF) -> ADDR_im_o=0x7FF after EXEC. Repeat with z_i=0 -> ADDR_im_o=PC+1.
- Wrap and stall: PC=0x7FF with LDI -> next ADDR_im_o=0. Instr_valid_i=0 for 3 cycles in FETCH -> ADDR_im_o stable, controls 0, no EXEC.
- HLT (0x0000) -> Halted_o=1 and PC held over 5 cycles. A Run_i pulse -> Halted_o=0 and ADDR_im_o=PC+1.
- STO (0x0805) in EXEC with Reset_i asserted that cycle -> WrRam_o=0 in the same cycle, and after the edge ADDR_im_o=RESET_PC.
